// File: rtl/collision_sched_pkg.sv
// Shared widths, requester indices and FSM encoding for the collision sequencer.
package collision_pkg;

  localparam int unsigned VEL_W = 32;
  localparam int unsigned ANG_W = 17;

  localparam int unsigned REQ_PADDLE_A = 0;
  localparam int unsigned REQ_PADDLE_B = 1;
  localparam int unsigned REQ_WALL     = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  // Round-robin successor of an index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/collision_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
module rr_arbiter
  import collision_pkg::*;
#(
  parameter  int unsigned N_REQ = 3,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W:0]     sum;

  // Rotate eligible so bit 0 is the pointer position, then take the first set bit.
  always_comb begin
    doubled     = {eligible, eligible} >> ptr;
    rotated     = doubled[N_REQ-1:0];
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!grant_valid && rotated[j]) begin
        grant_valid = 1'b1;
        sum = {1'b0, ptr} + (IDX_W+1)'(j);
        if (sum >= (IDX_W+1)'(N_REQ)) begin
          sum = sum - (IDX_W+1)'(N_REQ);
        end
        grant_idx = sum[IDX_W-1:0];
      end
    end
    if (grant_valid) begin
      grant = N_REQ'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/collision_sched.sv
// Collision sequencer: arbitrates requesters, strobes the datapath, captures the result.
module collision_sched
  import collision_pkg::*;
#(
  parameter  int unsigned N_REQ      = 3,
  parameter  int unsigned DP_LATENCY = 1,
  parameter  int unsigned HOLDOFF    = 8,
  localparam int unsigned IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [VEL_W-1:0] ball_velocity,
  input  logic [ANG_W-1:0] ball_angle,
  output logic             compute_collide,
  output logic [VEL_W-1:0] dp_velocity,
  output logic [ANG_W-1:0] dp_angle,
  input  logic [VEL_W-1:0] coll_velocity,
  input  logic [ANG_W-1:0] coll_angle,
  input  logic             coll_break,
  output logic [N_REQ-1:0] ack,
  output logic [IDX_W-1:0] grant_id,
  output logic             busy,
  output logic [VEL_W-1:0] out_velocity,
  output logic [ANG_W-1:0] out_angle,
  output logic             out_valid,
  output logic             halted,
  input  logic             resume
);

  localparam int unsigned HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int unsigned LAT_W = 4;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             compute_q, compute_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             out_valid_q, out_valid_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [VEL_W-1:0] dp_velocity_q, dp_velocity_d;
  logic [ANG_W-1:0] dp_angle_q, dp_angle_d;
  logic [VEL_W-1:0] out_velocity_q, out_velocity_d;
  logic [ANG_W-1:0] out_angle_q, out_angle_d;
  logic [HO_W-1:0]  hcnt_q [N_REQ];
  logic [HO_W-1:0]  hcnt_d [N_REQ];

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  // A source is masked while its hold-off counter is nonzero, including the expiry edge.
  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      masked[i] = (hcnt_q[i] != '0);
    end
    eligible = req & ~masked;
  end

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .eligible    (eligible),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Next-state, operand/result capture and hold-off bookkeeping.
  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    ptr_d          = ptr_q;
    busy_d         = busy_q;
    halted_d       = halted_q;
    lat_d          = lat_q;
    dp_velocity_d  = dp_velocity_q;
    dp_angle_d     = dp_angle_q;
    out_velocity_d = out_velocity_q;
    out_angle_d    = out_angle_q;
    compute_d      = 1'b0;
    ack_d          = '0;
    out_valid_d    = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      hcnt_d[i] = masked[i] ? hcnt_q[i] - 1'b1 : hcnt_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d       = ST_ISSUE;
          grant_id_d    = arb_idx;
          dp_velocity_d = ball_velocity;
          dp_angle_d    = ball_angle;
          busy_d        = 1'b1;
          compute_d     = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (DP_LATENCY <= 1) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT;
          lat_d   = LAT_W'(DP_LATENCY - 1);
        end
      end
      ST_WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q <= LAT_W'(1)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        out_velocity_d     = coll_velocity;
        out_angle_d        = coll_angle;
        out_valid_d        = 1'b1;
        ack_d[grant_id_q]  = 1'b1;
        hcnt_d[grant_id_q] = HO_W'(HOLDOFF);
        ptr_d              = IDX_W'(rr_next(32'(grant_id_q), N_REQ));
        if (coll_break) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d  = ST_IDLE;
          halted_d = 1'b0;
          busy_d   = 1'b0;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            hcnt_d[i] = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any service in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grant_id_q     <= '0;
      ptr_q          <= '0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
      compute_q      <= 1'b0;
      ack_q          <= '0;
      out_valid_q    <= 1'b0;
      lat_q          <= '0;
      dp_velocity_q  <= '0;
      dp_angle_q     <= '0;
      out_velocity_q <= '0;
      out_angle_q    <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        hcnt_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      ptr_q          <= ptr_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
      compute_q      <= compute_d;
      ack_q          <= ack_d;
      out_valid_q    <= out_valid_d;
      lat_q          <= lat_d;
      dp_velocity_q  <= dp_velocity_d;
      dp_angle_q     <= dp_angle_d;
      out_velocity_q <= out_velocity_d;
      out_angle_q    <= out_angle_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

  assign compute_collide = compute_q;
  assign dp_velocity     = dp_velocity_q;
  assign dp_angle        = dp_angle_q;
  assign ack             = ack_q;
  assign grant_id        = grant_id_q;
  assign busy            = busy_q;
  assign out_velocity    = out_velocity_q;
  assign out_angle       = out_angle_q;
  assign out_valid       = out_valid_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_collision_sched.sv
// Bench for collision_sched: four parameterisations share one stimulus stream,
// each checked every cycle against a timestamp-based service model.
module tb_collision_sched;
  import collision_pkg::*;

  localparam int NK = 4;
  localparam int unsigned LAT [NK] = '{1, 1, 4, 15};
  localparam int unsigned HO  [NK] = '{8, 0, 8, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  req;
  logic [31:0] ball_velocity, coll_velocity;
  logic [16:0] ball_angle, coll_angle;
  logic        coll_break, resume;

  logic        cc_w   [NK];
  logic [31:0] dpv_w  [NK];
  logic [16:0] dpa_w  [NK];
  logic [2:0]  ack_w  [NK];
  logic [1:0]  gid_w  [NK];
  logic        busy_w [NK];
  logic [31:0] outv_w [NK];
  logic [16:0] outa_w [NK];
  logic        val_w  [NK];
  logic        halt_w [NK];

  for (genvar g = 0; g < NK; g++) begin : g_dut
    collision_sched #(
      .N_REQ      (3),
      .DP_LATENCY (LAT[g]),
      .HOLDOFF    (HO[g])
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req),
      .ball_velocity   (ball_velocity),
      .ball_angle      (ball_angle),
      .compute_collide (cc_w[g]),
      .dp_velocity     (dpv_w[g]),
      .dp_angle        (dpa_w[g]),
      .coll_velocity   (coll_velocity),
      .coll_angle      (coll_angle),
      .coll_break      (coll_break),
      .ack             (ack_w[g]),
      .grant_id        (gid_w[g]),
      .busy            (busy_w[g]),
      .out_velocity    (outv_w[g]),
      .out_angle       (outa_w[g]),
      .out_valid       (val_w[g]),
      .halted          (halt_w[g]),
      .resume          (resume)
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a service is described by its grant edge; the result is
  // taken LAT+1 edges later; a served source is eligible again HO+1 edges after
  // its completion edge.
  int          n_edge;
  bit          m_busy  [NK];
  bit          m_halt  [NK];
  int          m_gedge [NK];
  int          m_gid   [NK];
  int          m_ptr   [NK];
  int          m_elig  [NK][3];
  bit          e_cc    [NK];
  logic [2:0]  e_ack   [NK];
  bit          e_ov    [NK];
  logic [31:0] e_dpv   [NK];
  logic [16:0] e_dpa   [NK];
  logic [31:0] e_outv  [NK];
  logic [16:0] e_outa  [NK];

  task automatic model_reset(input int k);
    m_busy[k] = 0; m_halt[k] = 0; m_gedge[k] = 0; m_gid[k] = 0; m_ptr[k] = 0;
    for (int i = 0; i < 3; i++) m_elig[k][i] = 0;
    e_cc[k] = 0; e_ack[k] = '0; e_ov[k] = 0;
    e_dpv[k] = '0; e_dpa[k] = '0; e_outv[k] = '0; e_outa[k] = '0;
  endtask

  task automatic model_step();
    n_edge++;
    for (int k = 0; k < NK; k++) begin
      if (!rst_n) begin
        model_reset(k);
      end else begin
        e_cc[k] = 0; e_ack[k] = '0; e_ov[k] = 0;
        if (!m_busy[k]) begin
          for (int off = 0; off < 3; off++) begin
            int i;
            i = (m_ptr[k] + off) % 3;
            if (req[i[1:0]] && n_edge >= m_elig[k][i]) begin
              m_busy[k] = 1; m_gedge[k] = n_edge; m_gid[k] = i;
              e_cc[k] = 1; e_dpv[k] = ball_velocity; e_dpa[k] = ball_angle;
              break;
            end
          end
        end else if (m_halt[k]) begin
          if (resume) begin
            m_halt[k] = 0; m_busy[k] = 0;
            for (int i = 0; i < 3; i++) m_elig[k][i] = 0;
          end
        end else if (n_edge == m_gedge[k] + int'(LAT[k]) + 1) begin
          e_outv[k] = coll_velocity; e_outa[k] = coll_angle; e_ov[k] = 1;
          e_ack[k] = 3'b001 << m_gid[k];
          m_elig[k][m_gid[k]] = n_edge + int'(HO[k]) + 1;
          m_ptr[k] = (m_gid[k] + 1) % 3;
          if (coll_break) m_halt[k] = 1;
          else m_busy[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp_v);
    end
  endtask

  task automatic check_model(input int k);
    int gexp;
    gexp = m_gid[k];
    chk("compute_collide", k, 64'(cc_w[k]),   64'(e_cc[k]));
    chk("ack",             k, 64'(ack_w[k]),  64'(e_ack[k]));
    chk("out_valid",       k, 64'(val_w[k]),  64'(e_ov[k]));
    chk("busy",            k, 64'(busy_w[k]), 64'(m_busy[k]));
    chk("halted",          k, 64'(halt_w[k]), 64'(m_halt[k]));
    chk("grant_id",        k, 64'(gid_w[k]),  64'(gexp));
    chk("dp_velocity",     k, 64'(dpv_w[k]),  64'(e_dpv[k]));
    chk("dp_angle",        k, 64'(dpa_w[k]),  64'(e_dpa[k]));
    chk("out_velocity",    k, 64'(outv_w[k]), 64'(e_outv[k]));
    chk("out_angle",       k, 64'(outa_w[k]), 64'(e_outa[k]));
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    for (int k = 0; k < NK; k++) check_model(k);
  endtask

  task automatic clear_inputs();
    req = '0; ball_velocity = '0; ball_angle = '0;
    coll_velocity = '0; coll_angle = '0; coll_break = 1'b0; resume = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic        cc;
    logic [2:0]  ack;
    logic        ov;
    logic        busy;
    logic [31:0] dpv;
    logic [31:0] outv;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int cnt, t_prev, c_ack;
    logic [2:0] exp_seq [3];
    logic [16:0] last_ang;

    tbl[0] = '{3'b001, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0001_0020, 32'h0};
    tbl[1] = '{3'b001, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0001_0020, 32'h0};
    tbl[2] = '{3'b001, 1'b0, 3'b001, 1'b1, 1'b0, 32'h0001_0020, 32'h0};
    tbl[3] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0001_0020, 32'h0};

    n_edge = 0;
    for (int k = 0; k < NK; k++) model_reset(k);
    do_reset();

    // Reset state.
    for (int k = 0; k < NK; k++) begin
      chk("rst_busy",  k, 64'(busy_w[k]), 64'd0);
      chk("rst_grant", k, 64'(gid_w[k]),  64'd0);
      chk("rst_dpv",   k, 64'(dpv_w[k]),  64'd0);
      chk("rst_halt",  k, 64'(halt_w[k]), 64'd0);
    end

    // Single request, latency 1 (dut0).
    ball_velocity = 32'h0001_0020;
    for (int r = 0; r < 4; r++) begin
      req = tbl[r].req;
      tick();
      chk("tbl_cc",   0, 64'(cc_w[0]),   64'(tbl[r].cc));
      chk("tbl_ack",  0, 64'(ack_w[0]),  64'(tbl[r].ack));
      chk("tbl_ov",   0, 64'(val_w[0]),  64'(tbl[r].ov));
      chk("tbl_busy", 0, 64'(busy_w[0]), 64'(tbl[r].busy));
      chk("tbl_dpv",  0, 64'(dpv_w[0]),  64'(tbl[r].dpv));
      chk("tbl_outv", 0, 64'(outv_w[0]), 64'(tbl[r].outv));
    end

    // Round-robin with no hold-off (dut1): 0,1,2,0 three cycles apart.
    do_reset();
    req = 3'b111;
    cnt = 0; t_prev = 0;
    for (int c = 0; c < 30 && cnt < 4; c++) begin
      tick();
      if (ack_w[1] != '0) begin
        chk("rr_order", 1, 64'(ack_w[1]), 64'(3'b001 << (cnt % 3)));
        if (cnt > 0) chk("rr_spacing", 1, 64'(c - t_prev), 64'd3);
        t_prev = c;
        cnt++;
      end
    end
    chk("rr_ack_count", 1, 64'(cnt), 64'd4);

    // Hold-off 8 (dut0): source 1 fills the gap, source 0 returns 11 cycles later.
    do_reset();
    req = 3'b011;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001;
    cnt = 0; t_prev = 0; c_ack = 0;
    for (int c = 0; c < 40 && cnt < 3; c++) begin
      tick();
      if (ack_w[0] != '0) begin
        chk("ho_order", 0, 64'(ack_w[0]), 64'(exp_seq[cnt]));
        if (cnt == 0) c_ack = c;
        if (cnt == 1) chk("ho_gap_src1", 0, 64'(c - t_prev), 64'd3);
        if (cnt == 2) chk("ho_gap_src0", 0, 64'(c - c_ack), 64'd11);
        t_prev = c;
        cnt++;
      end
    end
    chk("ho_ack_count", 0, 64'(cnt), 64'd3);

    // Break on first service (dut0), then resume.
    do_reset();
    req = 3'b001; coll_break = 1'b1;
    tick(); tick(); tick();
    chk("brk_ack",  0, 64'(ack_w[0]),  64'(3'b001));
    chk("brk_halt", 0, 64'(halt_w[0]), 64'd1);
    chk("brk_busy", 0, 64'(busy_w[0]), 64'd1);
    coll_break = 1'b0; req = 3'b111;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("halt_no_issue", 0, 64'(cc_w[0]), 64'd0);
    end
    resume = 1'b1;
    tick();
    chk("resume_halt", 0, 64'(halt_w[0]), 64'd0);
    chk("resume_busy", 0, 64'(busy_w[0]), 64'd0);
    resume = 1'b0;
    tick();
    chk("resume_grant_cc", 0, 64'(cc_w[0]),  64'd1);
    chk("resume_grant_id", 0, 64'(gid_w[0]), 64'd1);

    // Reset during WAIT (dut2, latency 4).
    do_reset();
    req = 3'b001; ball_velocity = 32'hDEAD_BEEF; ball_angle = 17'h1_2345;
    tick();
    chk("mw_issue", 2, 64'(cc_w[2]), 64'd1);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mw_cc",   2, 64'(cc_w[2]),   64'd0);
    chk("mw_ack",  2, 64'(ack_w[2]),  64'd0);
    chk("mw_ov",   2, 64'(val_w[2]),  64'd0);
    chk("mw_busy", 2, 64'(busy_w[2]), 64'd0);
    chk("mw_gid",  2, 64'(gid_w[2]),  64'd0);
    chk("mw_dpv",  2, 64'(dpv_w[2]),  64'd0);
    chk("mw_dpa",  2, 64'(dpa_w[2]),  64'd0);
    tick();
    rst_n = 1'b1; req = 3'b111;
    tick();
    chk("mw_first_cc",  2, 64'(cc_w[2]),  64'd1);
    chk("mw_first_gid", 2, 64'(gid_w[2]), 64'd0);

    // Latency 15 (dut3): ack 16 edges after grant, result from that edge only.
    do_reset();
    req = 3'b001;
    tick();
    chk("lat_issue", 3, 64'(cc_w[3]), 64'd1);
    c_ack = -1;
    for (int c = 1; c < 30 && c_ack < 0; c++) begin
      coll_angle = 17'($urandom);
      coll_velocity = $urandom;
      last_ang = coll_angle;
      tick();
      if (ack_w[3] != '0) begin
        c_ack = c;
        chk("lat_out_angle", 3, 64'(outa_w[3]), 64'(last_ang));
      end
    end
    chk("lat_ack_edge", 3, 64'(c_ack), 64'd16);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      req           = 3'($urandom);
      ball_velocity = $urandom;
      ball_angle    = 17'($urandom);
      coll_velocity = $urandom;
      coll_angle    = 17'($urandom);
      coll_break    = ($urandom_range(0, 7) == 0);
      resume        = ($urandom_range(0, 5) == 0);
      rst_n         = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/collision_sched.md
Name: collision_sched

Overview:
Sequencer and arbiter for the ball collision datapath in the pingpong motion game. Three collision sources compete for the single collision processor: paddle A, paddle B and the table/wall detector. The block grants one source at a time, drives the datapath's compute strobe and its ball-state inputs, and captures the result. It suppresses repeat hits from the same source during a hold-off window, and latches a game halt when the datapath reports a break.

Parameters:
N_REQ, 3, number of collision requesters (0 = paddle A, 1 = paddle B, 2 = wall)
DP_LATENCY, 1, clock edges from compute strobe until the datapath result is valid (1..15)
HOLDOFF, 8, cycles a just-served requester is masked (0 disables masking)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  level collision requests, one per source
ball_velocity  in  32  current ball velocity from the motion core
ball_angle  in  17  current ball angle from the motion core
compute_collide  out  1  strobe to the collision datapath
dp_velocity  out  32  velocity operand latched for the datapath
dp_angle  out  17  angle operand latched for the datapath
coll_velocity  in  32  datapath result velocity
coll_angle  in  17  datapath result angle
coll_break  in  1  datapath break flag
ack  out  N_REQ  one-hot, one-cycle completion pulse to the served source
grant_id  out  clog2(N_REQ)  index of the source being or last served
busy  out  1  high from grant until return to IDLE
out_velocity  out  32  captured result velocity
out_angle  out  17  captured result angle
out_valid  out  1  one-cycle pulse when out_* update
halted  out  1  sticky break indication
resume  in  1  pulse that clears halted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, round-robin pointer=0, hold-off counters=0. Reset asserted mid-operation aborts immediately, with no ack and no out_valid.
- States: IDLE, ISSUE, WAIT, CAPTURE, HALT.
- IDLE: eligible = req & ~masked. If any source is eligible, go to ISSUE at that edge E0. On the same edge: latch the winner into grant_id, latch ball_velocity/ball_angle into dp_*, set busy=1.
- Arbitration: round-robin. Search starts at the index after the last grant, wrapping at N_REQ. After reset, source 0 has top priority. Requests that arrive while busy are not queued; a source must hold req until it sees ack.
- ISSUE: compute_collide=1 for exactly one cycle. dp_* stay stable until the next grant. Go to WAIT with counter=DP_LATENCY-1; if DP_LATENCY=1, go directly to CAPTURE.
- WAIT: decrement the counter; at 0 go to CAPTURE.
- CAPTURE: sample coll_* at edge E0+DP_LATENCY+1. On that edge:
  - out_velocity/out_angle update.
  - out_valid=1 and ack[grant_id]=1, both for one cycle.
  - The hold-off counter of grant_id loads HOLDOFF.
  - The pointer moves to grant_id+1 mod N_REQ.
  - If coll_break=1: go to HALT and set halted=1. Otherwise go to IDLE with busy=0.
- Hold-off: each source has a counter that decrements every cycle while nonzero. masked[i] = (counter_i != 0). Counters keep running in every state, including HALT.
- HALT: busy stays 1 and all req are ignored. A resume pulse moves to IDLE, clears halted and busy, and zeroes all hold-off counters. resume in any other state is ignored.
- Simultaneous events: a req and the expiry of its own hold-off on the same edge counts as masked; the source becomes eligible on the next edge.
- Outputs are registered; there is no combinational path from req to compute_collide.

Decomposition:
- Shared package collision_pkg: VEL_W=32, ANG_W=17, requester index constants (REQ_PADDLE_A=0, REQ_PADDLE_B=1, REQ_WALL=2), and the state encoding.
- One sub-module: rr_arbiter (N_REQ-wide; inputs eligible vector and pointer; outputs one-hot grant and index; combinational).
- FSM, counters and capture registers live in collision_sched.

Test Plan:
- Single request: req=3'b001, ball_velocity=32'h0001_0020, DP_LATENCY=1, coll_velocity echoes 0. Expect compute_collide high one cycle after E0, dp_velocity=32'h0001_0020, and ack=3'b001 with out_valid=1 at E2, where out_velocity=0.
- Round-robin: req=3'b111 held, HOLDOFF=0. Expect grant order 0,1,2,0, each ack exactly 3 cycles apart.
- Hold-off: HOLDOFF=8, req[0] held continuously. Expect the second ack[0] no earlier than 9 cycles after the first. With req[1] also held, source 1 is served in between.
- Break: coll_break=1 on the first service. Expect halted=1 and busy=1; req=3'b111 for 20 cycles produces no compute_collide. A resume pulse gives halted=0, and the next grant follows one cycle later.
- Reset mid-WAIT: DP_LATENCY=4, drop rst_n two cycles after ISSUE. Expect all outputs 0 immediately, no ack, and after release source 0 wins first.
- Latency sweep: DP_LATENCY=15. Expect the ack edge 16 edges after E0 and out_angle equal to the coll_angle presented at that edge only.
